// File: rtl/data_mem_ctrl_pkg.sv
// Shared encodings for the data memory controller: access sizes, FSM states and
// the legal range of the response latency parameter.
package data_mem_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 4;

  function automatic bit read_lat_legal(input int lat);
    return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
  endfunction

endpackage

// File: rtl/data_mem_extend.sv
// Selects the addressed byte/half-word lane of a memory word and sign- or
// zero-extends it; word accesses pass through unchanged.
module data_mem_extend
  import data_mem_ctrl_pkg::*;
#(
  parameter int WORD_LEN = 32
) (
  input  logic [WORD_LEN-1:0] word,
  input  logic [1:0]          byte_off,
  input  logic [1:0]          size,
  input  logic                is_unsigned,
  output logic [WORD_LEN-1:0] data
);

  logic [WORD_LEN-1:0] shifted;

  always_comb begin
    shifted = word >> {byte_off, 3'b000};
    data    = '0;
    case (size)
      SZ_BYTE: data = {{(WORD_LEN-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_HALF: data = {{(WORD_LEN-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
      SZ_WORD: data = shifted;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressed little-endian data memory with fixed-latency responses and a
// self-clearing start-up sequence after reset.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int WORD_LEN = 32,
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_we,
  input  logic [1:0]          i_req_size,
  input  logic                i_req_unsigned,
  input  logic [WORD_LEN-1:0] i_req_addr,
  input  logic [WORD_LEN-1:0] i_req_wdata,
  output logic                o_rsp_valid,
  output logic [WORD_LEN-1:0] o_rsp_rdata,
  output logic                o_rsp_err,
  input  logic [ADDR_W-3:0]   i_dbg_addr,
  output logic [WORD_LEN-1:0] o_dbg_word
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int NWORDS = DEPTH / 4;
  localparam int IW     = ADDR_W - 2;
  // An out-of-range latency falls back to single-cycle responses.
  localparam int LAT    = read_lat_legal(READ_LAT) ? READ_LAT : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  state_t              state, state_nxt;
  logic [WORD_LEN-1:0] mem [NWORDS];
  logic [IW-1:0]       clr_idx;
  logic [1:0]          lat_cnt;
  logic [WORD_LEN-1:0] pend_rdata;
  logic                pend_err;
  logic                accept, fault, fire;
  logic [IW-1:0]       word_idx;
  logic [WORD_LEN-1:0] rd_word, ext_data, wr_data;
  logic [3:0]          be;

  assign accept     = i_req_valid && o_req_ready && !i_rst;
  assign word_idx   = i_req_addr[ADDR_W-1:2];
  assign rd_word    = mem[word_idx];
  assign wr_data    = i_req_wdata << {i_req_addr[1:0], 3'b000};
  assign o_dbg_word = mem[i_dbg_addr];

  always_comb begin
    fault = 1'b0;
    be    = 4'b0000;
    case (i_req_size)
      SZ_BYTE: be = 4'b0001;
      SZ_HALF: begin be = 4'b0011; fault = i_req_addr[0]; end
      SZ_WORD: begin be = 4'b1111; fault = |i_req_addr[1:0]; end
      default: fault = 1'b1;
    endcase
    be = be << i_req_addr[1:0];
    if (|i_req_addr[WORD_LEN-1:ADDR_W]) fault = 1'b1;
  end

  data_mem_extend #(.WORD_LEN(WORD_LEN)) u_extend (
    .word        (rd_word),
    .byte_off    (i_req_addr[1:0]),
    .size        (i_req_size),
    .is_unsigned (i_req_unsigned),
    .data        (ext_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_req_ready = 1'b0;
    fire        = 1'b0;
    case (state)
      ST_CLEAR: if (clr_idx == LAST_IDX) state_nxt = ST_IDLE;
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_cnt == 2'd0) begin
          fire      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      clr_idx     <= '0;
      lat_cnt     <= '0;
      pend_rdata  <= '0;
      pend_err    <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      o_rsp_valid <= fire;
      if (state == ST_CLEAR) clr_idx <= clr_idx + 1'b1;
      if (accept) begin
        lat_cnt    <= 2'(LAT - 1);
        pend_rdata <= (fault || i_req_we) ? '0 : ext_data;
        pend_err   <= fault;
      end else if (state == ST_WAIT && lat_cnt != 2'd0) begin
        lat_cnt <= lat_cnt - 2'd1;
      end
      if (fire) begin
        o_rsp_rdata <= pend_rdata;
        o_rsp_err   <= pend_err;
      end
    end
  end

  // Memory has no reset; the CLEAR sequence zeroes it one word per cycle.
  always_ff @(posedge i_clk) begin
    if (state == ST_CLEAR && !i_rst) begin
      mem[clr_idx] <= '0;
    end else if (accept && i_req_we && !fault) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one default-latency instance for function
// and reset behaviour, one READ_LAT=3 instance for back-to-back timing.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, rsp_rdata, dbg_word;
  logic        rsp_valid, rsp_err;
  logic [7:0]  dbg_addr;

  logic        rst2, req_valid2, req_ready2, rsp_valid2, rsp_err2;
  logic [31:0] rsp_rdata2, dbg_word2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_ctrl u_dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_rsp_valid(rsp_valid),
    .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err), .i_dbg_addr(dbg_addr),
    .o_dbg_word(dbg_word)
  );

  data_mem_ctrl #(.READ_LAT(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst2), .i_req_valid(req_valid2), .o_req_ready(req_ready2),
    .i_req_we(1'b0), .i_req_size(SZ_WORD), .i_req_unsigned(1'b0),
    .i_req_addr(32'h0), .i_req_wdata(32'h0), .o_rsp_valid(rsp_valid2),
    .o_rsp_rdata(rsp_rdata2), .o_rsp_err(rsp_err2), .i_dbg_addr(8'h00),
    .o_dbg_word(dbg_word2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
    int k;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    check("req_ready_wait", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_wdata = 32'hDEAD_0000;
    k = 0;
    while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
    check("rsp_latency", k, 32'd1);
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  // Asserts reset for one edge from the current negedge, then counts cycles
  // with ready low; notes any response seen meanwhile.
  task automatic reset_count(output int n, output logic saw_rsp);
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    saw_rsp = rsp_valid;
    rst = 1'b0;
    n = 0;
    while (!req_ready && n < 1000) begin
      saw_rsp = saw_rsp | rsp_valid;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er, saw;
    int          n;
    int          acc_cyc[8], rsp_cyc[8];
    int          acc_n, rsp_n;

    rst = 1'b1; rst2 = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0;
    req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; dbg_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'b0, rsp_err}, 32'd0);
    rst = 1'b0; rst2 = 1'b0;

    // Interrupt the first clear part-way through; the count restarts at zero.
    repeat (100) @(negedge clk);
    check("clear_mid_ready", {31'b0, req_ready}, 32'd0);
    reset_count(n, saw);
    check("clear_cycles", n, 32'd256);
    check("clear_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 256; i++) begin
      dbg_addr = 8'(i);
      #1;
      check("clear_dbg_zero", dbg_word, 32'd0);
    end

    do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h8081_F2F3, rd, er);
    check("st_w_rdata", rd, 32'd0);
    check("st_w_err", {31'b0, er}, 32'd0);
    dbg_addr = 8'd4; #1;
    check("st_w_dbg", dbg_word, 32'h8081_F2F3);
    dbg_addr = 8'd5; #1;
    check("st_w_dbg_next", dbg_word, 32'd0);

    do_req(1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0, rd, er);
    check("ld_b_signed", rd, 32'hFFFF_FFF3);
    check("ld_b_signed_err", {31'b0, er}, 32'd0);
    @(negedge clk);
    check("rsp_pulse_one", {31'b0, rsp_valid}, 32'd0);
    check("rsp_rdata_hold", rsp_rdata, 32'hFFFF_FFF3);
    do_req(1'b0, SZ_BYTE, 1'b1, 32'h10, 32'h0, rd, er);
    check("ld_b_unsigned", rd, 32'h0000_00F3);
    do_req(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, rd, er);
    check("ld_h_signed", rd, 32'hFFFF_8081);
    do_req(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, rd, er);
    check("ld_b3_unsigned", rd, 32'h0000_0080);
    do_req(1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, rd, er);
    check("ld_h_unsigned", rd, 32'h0000_F2F3);

    do_req(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h1234_56AB, rd, er);
    dbg_addr = 8'd4; #1;
    check("st_b_dbg", dbg_word, 32'h8081_ABF3);
    do_req(1'b1, SZ_HALF, 1'b0, 32'h12, 32'hCCCC_7FFE, rd, er);
    dbg_addr = 8'd4; #1;
    check("st_h_dbg", dbg_word, 32'h7FFE_ABF3);
    do_req(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, rd, er);
    check("ld_h_pos_signed", rd, 32'h0000_7FFE);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd, er);
    check("ld_w", rd, 32'h7FFE_ABF3);

    do_req(1'b0, SZ_HALF, 1'b0, 32'h11, 32'h0, rd, er);
    check("ld_h_misalign_err", {31'b0, er}, 32'd1);
    check("ld_h_misalign_rdata", rd, 32'd0);
    do_req(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h1122_3344, rd, er);
    check("st_w20_err", {31'b0, er}, 32'd0);
    do_req(1'b1, SZ_WORD, 1'b0, 32'h22, 32'hAAAA_BBBB, rd, er);
    check("st_w_misalign_err", {31'b0, er}, 32'd1);
    check("st_w_misalign_rdata", rd, 32'd0);
    dbg_addr = 8'd8; #1;
    check("st_w_misalign_dbg8", dbg_word, 32'h1122_3344);
    dbg_addr = 8'd9; #1;
    check("st_w_misalign_dbg9", dbg_word, 32'd0);

    do_req(1'b0, SZ_WORD, 1'b0, 32'h400, 32'h0, rd, er);
    check("ld_oob_err", {31'b0, er}, 32'd1);
    check("ld_oob_rdata", rd, 32'd0);
    do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, rd, er);
    check("ld_size11_err", {31'b0, er}, 32'd1);
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h400, 32'h0000_0055, rd, er);
    check("st_oob_err", {31'b0, er}, 32'd1);
    dbg_addr = 8'd0; #1;
    check("st_oob_dbg0", dbg_word, 32'd0);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h3FC, 32'h0, rd, er);
    check("ld_top_word_err", {31'b0, er}, 32'd0);

    // Reset while a load is in WAIT: no response, full clear, data gone.
    do_req(1'b1, SZ_WORD, 1'b0, 32'h40, 32'hDEAD_BEEF, rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; req_addr = 32'h40;
    check("wait_rst_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    check("wait_rst_in_wait", {31'b0, req_ready}, 32'd0);
    reset_count(n, saw);
    check("wait_rst_no_rsp", {31'b0, saw}, 32'd0);
    check("wait_rst_clear_cycles", n, 32'd256);
    dbg_addr = 8'd16; #1;
    check("wait_rst_dbg16", dbg_word, 32'd0);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, rd, er);
    check("wait_rst_ld", rd, 32'd0);
    check("wait_rst_ld_err", {31'b0, er}, 32'd0);

    // READ_LAT=3 instance with valid held high.
    @(negedge clk);
    check("lat3_ready", {31'b0, req_ready2}, 32'd1);
    req_valid2 = 1'b1;
    acc_n = 0; rsp_n = 0;
    for (int c = 0; c < 20; c++) begin
      if (req_ready2 && acc_n < 8) begin acc_cyc[acc_n] = c + 1; acc_n++; end
      if (rsp_valid2 && rsp_n < 8) begin rsp_cyc[rsp_n] = c; rsp_n++; end
      @(negedge clk);
    end
    req_valid2 = 1'b0;
    check("lat3_accepts", acc_n, 32'd5);
    check("lat3_responses", rsp_n, 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rsp_n && i < acc_n) check("lat3_rsp_delay", rsp_cyc[i] - acc_cyc[i], 32'd3);
      if (i + 1 < acc_n) check("lat3_acc_spacing", acc_cyc[i+1] - acc_cyc[i], 32'd4);
    end
    check("lat3_rdata", rsp_rdata2, 32'd0);
    check("lat3_err", {31'b0, rsp_err2}, 32'd0);
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
